// File: rtl/pkt_decoder.sv
// UART frame decoder: SYNC_BYTE header, PACK_NUM payload bytes, optional checksum
// byte (define PKT_CHECKSUM_EN), unpacked into registered output fields.
module pkt_decoder #(
  parameter int         DATA_BIT    = 32,
  parameter int         PACK_NUM    = 9,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_mode,
  output logic [3:0]          o_sel_out,
  output logic                o_done_tick,
  output logic                o_err_tick,
  output logic                o_busy,
  output logic [1:0]          o_dbg_state
);

  // Handshake: i_rx_done_tick qualifies i_data for exactly one cycle and there is
  // no backpressure, so every strobe is consumed in the cycle it arrives.

  localparam int FW  = 2*DATA_BIT + 7;
  localparam int BCW = $clog2(PACK_NUM + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
`ifdef PKT_CHECKSUM_EN
  localparam int SRW = 8*PACK_NUM;
`else
  // The last payload byte is taken straight from i_data, so one byte less is stored.
  localparam int SRW = 8*(PACK_NUM - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef PKT_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = S_CSUM;
`else
  localparam state_t AFTER_PAYLOAD = S_DONE;
`endif

  state_t          state;
  logic [BCW-1:0]  byte_cnt;
  logic [TCW-1:0]  tmo_cnt;
  logic [SRW-1:0]  shreg;
  logic [SRW-1:0]  shreg_nxt;
  logic [FW-1:0]   frame;
  logic            sync_hit;
  logic            last_byte;
  logic            tmo_hit;
  logic            load;

  assign shreg_nxt = {i_data, shreg[SRW-1:8]};
  assign sync_hit  = i_rx_done_tick && (i_data == SYNC_BYTE);
  assign last_byte = (byte_cnt == BCW'(PACK_NUM - 1));
  assign tmo_hit   = (tmo_cnt == TCW'(TIMEOUT_CYC - 1));

`ifdef PKT_CHECKSUM_EN
  logic [7:0] csum_acc;
  assign load  = (state == S_CSUM) && i_rx_done_tick && (i_data == csum_acc);
  assign frame = shreg[FW-1:0];
`else
  assign load  = (state == S_DATA) && i_rx_done_tick && last_byte;
  assign frame = FW'({i_data, shreg});
`endif

  assign o_busy      = (state != S_IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      o_err_tick <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      csum_acc   <= '0;
`endif
    end else begin
      o_err_tick <= 1'b0;
      case (state)
        // S_DONE hunts for sync too so a back-to-back header is not dropped.
        S_IDLE, S_DONE: begin
          if (sync_hit) begin
            state    <= S_DATA;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_acc <= '0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (i_rx_done_tick) begin
            shreg    <= shreg_nxt;
            byte_cnt <= byte_cnt + BCW'(1);
            tmo_cnt  <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_acc <= csum_acc + i_data;
`endif
            if (last_byte) state <= AFTER_PAYLOAD;
          end else if (tmo_hit) begin
            state      <= S_IDLE;
            o_err_tick <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
          end
        end
`ifdef PKT_CHECKSUM_EN
        S_CSUM: begin
          if (i_rx_done_tick) begin
            tmo_cnt <= '0;
            if (load) begin
              state <= S_DONE;
            end else begin
              state      <= S_IDLE;
              o_err_tick <= 1'b1;
            end
          end else if (tmo_hit) begin
            state      <= S_IDLE;
            o_err_tick <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output fields change only when a complete, accepted frame is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_output_pattern <= '0;
      o_freq_pattern   <= '0;
      o_start          <= 1'b0;
      o_stop           <= 1'b0;
      o_mode           <= 1'b0;
      o_sel_out        <= '0;
      o_done_tick      <= 1'b0;
    end else begin
      o_done_tick <= load;
      if (load) begin
        o_output_pattern <= frame[DATA_BIT-1:0];
        o_freq_pattern   <= frame[2*DATA_BIT-1:DATA_BIT];
        o_start          <= frame[2*DATA_BIT];
        o_stop           <= frame[2*DATA_BIT+1];
        o_mode           <= frame[2*DATA_BIT+2];
        o_sel_out        <= frame[2*DATA_BIT+6:2*DATA_BIT+3];
      end
    end
  end

endmodule

// File: doc/pkt_decoder.md
PKT_DECODER -- requirements
Module: pkt_decoder

Interface
REQ-001 Parameter DATA_BIT, default 32: width of the output-pattern and freq-pattern fields.
REQ-002 Parameter PACK_NUM, default 9: payload bytes per frame; must satisfy 8*PACK_NUM >= 2*DATA_BIT+7.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame header value.
REQ-004 Parameter TIMEOUT_CYC, default 50000: maximum clk cycles allowed between bytes inside a frame.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_data  input  8  received UART byte, valid only when i_rx_done_tick=1.
REQ-008 i_rx_done_tick  input  1  one-cycle byte-valid strobe.
REQ-009 o_output_pattern  output  DATA_BIT  registered payload bits [DATA_BIT-1:0].
REQ-010 o_freq_pattern  output  DATA_BIT  registered payload bits [2*DATA_BIT-1:DATA_BIT].
REQ-011 o_start, o_stop, o_mode  output  1 each  registered payload bits 2D, 2D+1, 2D+2 (D=DATA_BIT).
REQ-012 o_sel_out  output  4  registered payload bits [2D+6:2D+3].
REQ-013 o_done_tick  output  1  one-cycle pulse: new valid frame presented.
REQ-014 o_err_tick  output  1  one-cycle pulse: frame discarded (timeout or checksum).
REQ-015 o_busy  output  1  high in every state except S_IDLE.

Function
REQ-016 The FSM SHALL have states S_IDLE, S_DATA, S_CSUM, S_DONE.
REQ-017 S_IDLE: on strobe with i_data==SYNC_BYTE go S_DATA, clear byte counter, checksum accumulator and timeout counter; other bytes ignored.
REQ-018 S_DATA: each strobe shifts i_data into the MSB end of an 8*PACK_NUM shift register (right shift by 8), so the first payload byte ends in bits [7:0].
REQ-019 S_DATA: on the strobe of payload byte PACK_NUM, go S_CSUM if PKT_CHECKSUM_EN is defined, else S_DONE.
REQ-020 S_CSUM: next strobe is the checksum byte; it is compared, then go S_DONE (match) or S_IDLE with o_err_tick (mismatch).
REQ-021 S_DONE: lasts exactly one cycle; loads all output fields from the shift register, pulses o_done_tick, returns to S_IDLE.
REQ-022 Latency: o_done_tick and updated outputs SHALL appear the cycle after the strobe of the final frame byte.
REQ-023 Outputs SHALL hold their last valid frame until the next o_done_tick; discarded frames never alter them.
REQ-024 Timeout counter SHALL reset on every strobe in S_DATA/S_CSUM, otherwise increment; on reaching TIMEOUT_CYC go S_IDLE and pulse o_err_tick.
REQ-025 A strobe in the cycle the counter reaches TIMEOUT_CYC SHALL take priority (byte accepted, no timeout).
REQ-026 A strobe arriving during S_DONE SHALL be evaluated as an S_IDLE byte (sync hunt), so back-to-back frames are not lost.
REQ-027 Payload bytes equal to SYNC_BYTE SHALL be treated as data, not as resynchronisation.
REQ-028 Payload bits above 2D+6 are ignored.
REQ-029 o_done_tick and o_err_tick SHALL never be asserted in the same cycle.

Reset
REQ-030 On rst_n low: state S_IDLE; all counters, the shift register, the accumulator and every output SHALL be 0, immediately and asynchronously, including mid-frame.
REQ-031 After reset release, the first accepted frame SHALL require a fresh SYNC_BYTE.

Configuration
REQ-032 Macro PKT_CHECKSUM_EN defined: the frame carries a trailing byte that must equal the modulo-256 sum of the PACK_NUM payload bytes; S_CSUM and the accumulator exist.
REQ-033 Macro PKT_CHECKSUM_EN undefined: no checksum byte, no accumulator, S_CSUM is unreachable, and o_err_tick arises from timeout only.

Verification
REQ-034 Reset, then A5 followed by payload 01..09 (+checksum 2D if enabled) -> o_done_tick 1 cycle after the last strobe; o_output_pattern=32'h04030201, o_freq_pattern=32'h08070605, o_start=1, o_stop=0, o_mode=0, o_sel_out=1.
REQ-035 Bytes 00,FF,A5 then valid frame -> only one o_done_tick; leading junk ignored.
REQ-036 A5 + 4 payload bytes, then idle TIMEOUT_CYC cycles -> o_err_tick once, o_busy falls, outputs unchanged.
REQ-037 PKT_CHECKSUM_EN, checksum 2C instead of 2D -> o_err_tick, no o_done_tick, outputs hold the previous frame.
REQ-038 Second frame's A5 strobed in the S_DONE cycle of the first frame -> both frames decoded, two o_done_tick pulses.
REQ-039 rst_n pulsed low after payload byte 5 -> all outputs 0; the remaining bytes produce no o_done_tick.
